// File: rtl/muxn_pkg.sv
// Shared definitions for the muxn_scan sampler: mode encoding and index-width helpers.
package muxn_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_width(input int unsigned n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/muxn_scan_if.sv
// Control/data bundle between a source (master) and the muxn_scan sampler (slave).
interface muxn_scan_if
  import muxn_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 4
);
  localparam int unsigned SELW = idx_width(NCH);

  logic                   en;
  logic                   mode;
  logic [SELW-1:0]        sel;
  logic [NCH*WIDTH-1:0]   din;
  logic [WIDTH-1:0]       dout;
  logic [SELW-1:0]        ch;
  logic                   valid;
  logic                   tick;

  modport master (
    output en, mode, sel, din,
    input  dout, ch, valid, tick
  );

  modport slave (
    input  en, mode, sel, din,
    output dout, ch, valid, tick
  );
endinterface

// File: rtl/muxn_scan_ctr.sv
// Round-robin channel counter: holds each channel for DWELL enabled cycles.
module muxn_scan_ctr
  import muxn_pkg::*;
#(
  parameter int unsigned NCH   = 4,
  parameter int unsigned DWELL = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      clear,
  output logic [idx_width(NCH)-1:0] scan_ch,
  output logic                      first
);
  localparam int unsigned SELW = idx_width(NCH);
  localparam int unsigned CW   = idx_width(DWELL);
  localparam logic [CW-1:0]   DLAST = CW'(DWELL - 1);
  localparam logic [SELW-1:0] CLAST = SELW'(NCH - 1);

  logic [CW-1:0]   dwell_q, dwell_d;
  logic [SELW-1:0] ch_q, ch_d;

  always_comb begin
    dwell_d = dwell_q;
    ch_d    = ch_q;
    if (clear) begin
      dwell_d = '0;
      ch_d    = '0;
    end else if (dwell_q == DLAST) begin
      dwell_d = '0;
      ch_d    = (ch_q == CLAST) ? '0 : ch_q + 1'b1;
    end else begin
      dwell_d = dwell_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_q <= '0;
      ch_q    <= '0;
    end else if (en) begin
      dwell_q <= dwell_d;
      ch_q    <= ch_d;
    end
  end

  assign scan_ch = ch_q;
  assign first   = (dwell_q == '0);
endmodule

// File: rtl/muxn_scan.sv
// NCH-input, WIDTH-bit registered multiplexer with manual select or round-robin scan.
module muxn_scan
  import muxn_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 4,
  parameter int unsigned DWELL = 4
) (
  input  logic        clk,
  input  logic        rst,
  muxn_scan_if.slave  bus
);
  localparam int unsigned SELW = idx_width(NCH);

  logic [SELW-1:0]  scan_ch;
  logic             first;
  logic             is_scan;
  logic [SELW-1:0]  ch_cur;
  logic             in_range;
  logic [WIDTH-1:0] data_sel;

  logic [WIDTH-1:0] dout_q;
  logic [SELW-1:0]  ch_q;
  logic             valid_q;
  logic             tick_q, tick_d;

  assign is_scan = (bus.mode == MODE_SCAN);

  // Leaving scan mode clears the counter so the next scan entry starts at channel 0.
  muxn_scan_ctr #(
    .NCH   (NCH),
    .DWELL (DWELL)
  ) u_ctr (
    .clk     (clk),
    .rst     (rst),
    .en      (bus.en),
    .clear   (!is_scan),
    .scan_ch (scan_ch),
    .first   (first)
  );

  always_comb begin
    ch_cur   = is_scan ? scan_ch : bus.sel;
    in_range = ({1'b0, ch_cur} < (SELW + 1)'(NCH));
    data_sel = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (ch_cur == SELW'(k)) data_sel = bus.din[k*WIDTH +: WIDTH];
    end
    tick_d = bus.en & is_scan & first;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= tick_d;
      if (bus.en) begin
        dout_q  <= data_sel;
        ch_q    <= ch_cur;
        valid_q <= in_range;
      end
    end
  end

  assign bus.dout  = dout_q;
  assign bus.ch    = ch_q;
  assign bus.valid = valid_q;
  assign bus.tick  = tick_q;
endmodule

// File: tb/tb_muxn_scan.sv
// Directed checks for muxn_scan: reset, manual select, scan sequencing, enable freeze, mode switches.
module tb_muxn_scan;
  logic clk;
  logic rst;
  int   vecs;
  int   fails;

  muxn_scan_if #(.WIDTH(8), .NCH(4)) b  ();
  muxn_scan_if #(.WIDTH(8), .NCH(3)) b3 ();
  muxn_scan_if #(.WIDTH(8), .NCH(4)) b1 ();

  muxn_scan #(.WIDTH(8), .NCH(4), .DWELL(3)) dut  (.clk(clk), .rst(rst), .bus(b));
  muxn_scan #(.WIDTH(8), .NCH(3), .DWELL(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));
  muxn_scan #(.WIDTH(8), .NCH(4), .DWELL(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [7:0] EXP_MAN [4]  = '{8'h11, 8'h22, 8'h33, 8'h44};
  localparam logic [7:0] EXP3_D  [13] = '{8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22,
                                          8'h33, 8'h33, 8'h33, 8'h44, 8'h44, 8'h44, 8'h11};
  localparam logic [1:0] EXP3_C  [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
  localparam logic       EXP3_T  [13] = '{1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};
  localparam logic [7:0] EXP1_D  [13] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22, 8'h33,
                                          8'h44, 8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs  = 0;
    fails = 0;
    rst   = 1'b0;
    b.en  = 1'b0; b.mode  = 1'b0; b.sel  = '0; b.din  = {8'h44, 8'h33, 8'h22, 8'h11};
    b3.en = 1'b0; b3.mode = 1'b0; b3.sel = '0; b3.din = {8'h33, 8'h22, 8'h11};
    b1.en = 1'b0; b1.mode = 1'b0; b1.sel = '0; b1.din = {8'h44, 8'h33, 8'h22, 8'h11};

    // 1: asynchronous reset takes effect before any clock edge
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_dout",   b.dout,   0);
    chk("rst_ch",     b.ch,     0);
    chk("rst_valid",  b.valid,  0);
    chk("rst_tick",   b.tick,   0);
    chk("rst3_dout",  b3.dout,  0);
    chk("rst3_valid", b3.valid, 0);
    chk("rst1_dout",  b1.dout,  0);
    chk("rst1_tick",  b1.tick,  0);
    @(negedge clk);
    rst  = 1'b0;
    b.en = 1'b1;

    // 2: manual stepping
    for (int i = 0; i < 4; i++) begin
      b.sel = 2'(i);
      edge1();
      chk("man_dout",  b.dout,  EXP_MAN[i]);
      chk("man_ch",    b.ch,    i);
      chk("man_valid", b.valid, 1);
      chk("man_tick",  b.tick,  0);
    end

    // 3: scan from reset, plus DWELL=1 instance
    rst = 1'b1;
    #4 rst = 1'b0;
    b.mode  = 1'b1;
    b1.en   = 1'b1;
    b1.mode = 1'b1;
    for (int k = 0; k < 13; k++) begin
      edge1();
      chk("scan_dout",   b.dout,   EXP3_D[k]);
      chk("scan_ch",     b.ch,     EXP3_C[k]);
      chk("scan_tick",   b.tick,   EXP3_T[k]);
      chk("scan_valid",  b.valid,  1);
      chk("scan1_dout",  b1.dout,  EXP1_D[k]);
      chk("scan1_tick",  b1.tick,  1);
    end
    b1.en = 1'b0;

    // 4: enable freeze in the middle of the channel-1 dwell
    rst = 1'b1;
    #4 rst = 1'b0;
    for (int k = 0; k < 5; k++) edge1();
    chk("frz_pre_dout", b.dout, 8'h22);
    chk("frz_pre_tick", b.tick, 0);
    b.en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      edge1();
      chk("frz_dout", b.dout, 8'h22);
      chk("frz_ch",   b.ch,   1);
      chk("frz_tick", b.tick, 0);
    end
    b.en = 1'b1;
    edge1();
    chk("frz_last_dout", b.dout, 8'h22);
    chk("frz_last_tick", b.tick, 0);
    edge1();
    chk("frz_next_dout", b.dout, 8'h33);
    chk("frz_next_ch",   b.ch,   2);
    chk("frz_next_tick", b.tick, 1);

    // 6: scan -> manual -> scan restarts at channel 0
    b.mode = 1'b0;
    b.sel  = 2'd1;
    for (int k = 0; k < 2; k++) begin
      edge1();
      chk("sw_man_dout", b.dout, 8'h22);
      chk("sw_man_ch",   b.ch,   1);
      chk("sw_man_tick", b.tick, 0);
    end
    b.mode = 1'b1;
    for (int k = 0; k < 3; k++) begin
      edge1();
      chk("sw_scan_dout", b.dout, 8'h11);
      chk("sw_scan_ch",   b.ch,   0);
      chk("sw_scan_tick", b.tick, (k == 0) ? 1 : 0);
    end
    edge1();
    chk("sw_adv_dout", b.dout, 8'h22);
    chk("sw_adv_tick", b.tick, 1);

    // 5: NCH=3, out-of-range manual select
    b3.en  = 1'b1;
    b3.sel = 2'd3;
    edge1();
    chk("oor_dout",  b3.dout,  0);
    chk("oor_valid", b3.valid, 0);
    chk("oor_ch",    b3.ch,    3);
    chk("oor_tick",  b3.tick,  0);
    b3.sel = 2'd2;
    edge1();
    chk("inr_dout",  b3.dout,  8'h33);
    chk("inr_valid", b3.valid, 1);
    chk("inr_ch",    b3.ch,    2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule

// File: doc/muxn_scan.md
Name: muxn_scan

Overview:
- Parametrised successor to the 2:1 mux: an NCH-input, WIDTH-bit multiplexer with a registered output.
- Two modes:
  - Manual: the channel comes from the sel port.
  - Scan: an internal round-robin counter steps through channels, holding each one for DWELL enabled cycles.
- Used as the front-end sampler in the lab datapath, for example to cycle several sources onto one display or checker bus.

Parameters:
- WIDTH, 8, data bits per channel (>=1).
- NCH, 4, number of input channels (>=2, need not be a power of two).
- DWELL, 4, enabled cycles spent on each channel in scan mode (>=1).
- SELW, derived = max(1, clog2(NCH)), select/channel index width (localparam, not overridable).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- en  in  1  cycle enable; 0 freezes all state.
- mode  in  1  0 = manual, 1 = scan.
- sel  in  SELW  manual channel select.
- din  in  NCH*WIDTH  packed inputs; channel k occupies din[k*WIDTH +: WIDTH].
- dout  out  WIDTH  registered selected data.
- ch  out  SELW  channel index currently shown on dout.
- valid  out  1  dout holds a legal channel sample.
- tick  out  1  1-cycle pulse marking the first sample of a channel dwell in scan mode.

Behaviour:
- Reset: asynchronous, active-high. While rst=1: dout=0, ch=0, valid=0, tick=0, scan_ch=0, dwell_cnt=0. First update is on the first rising clk edge after rst falls.
- Current channel (combinational, internal): ch_cur = sel when mode=0; ch_cur = scan_ch when mode=1.
- Registered output, latency 1 cycle. On each rising edge with en=1:
  - dout <= din[ch_cur] if ch_cur < NCH, else 0.
  - ch <= ch_cur.
  - valid <= (ch_cur < NCH).
  - tick <= mode & (dwell_cnt == 0).
- en=0: dout, ch, valid, scan_ch and dwell_cnt all hold; tick <= 0.
- Manual mode:
  - sel changes take effect on dout one edge later.
  - Out-of-range sel (NCH not a power of two, sel >= NCH) gives dout=0, valid=0.
  - scan_ch and dwell_cnt are held at 0.
- Scan mode:
  - dwell_cnt counts 0..DWELL-1 on enabled cycles.
  - When dwell_cnt == DWELL-1: dwell_cnt <= 0 and scan_ch <= (scan_ch == NCH-1) ? 0 : scan_ch+1.
  - scan_ch never leaves 0..NCH-1, so valid stays 1 in scan mode.
  - DWELL=1: the channel advances every enabled cycle and tick is high continuously.
- Mode switches:
  - Manual->scan: scan always starts at channel 0 with dwell_cnt=0. The first scan sample therefore appears one edge after mode rises, with tick=1.
  - Scan->manual: the next edge follows sel; scan_ch and dwell_cnt clear to 0.
- Simultaneous events:
  - rst overrides everything.
  - en=0 overrides mode changes; mode is only sampled on enabled edges.
  - din changes during a dwell are tracked every enabled cycle. The output is a live mux, not a one-shot capture.
- Reset mid-scan aborts the dwell. After release, scanning resumes from channel 0.

Decomposition:
- Shared package muxn_pkg:
  - Mode constants MODE_MANUAL=1'b0 and MODE_SCAN=1'b1.
  - A clog2 constant function used for SELW.
- One sub-module, muxn_scan_ctr:
  - Holds the dwell_cnt / scan_ch counter pair.
  - Inputs clk, rst, en, clear, with parameters NCH and DWELL.
  - Outputs scan_ch and first (dwell_cnt == 0).
- Data selection and output registers stay in the top module.

Test Plan (WIDTH=8, NCH=4, DWELL=3 unless noted; din = {8'h44, 8'h33, 8'h22, 8'h11}, channel 0 = 8'h11):
1. Assert rst mid-cycle, asynchronously -> dout=0, ch=0, valid=0, tick=0 immediately, before any clk edge.
2. Manual mode, en=1, sel stepped 0,1,2,3 on consecutive cycles -> dout 11,22,33,44 one edge after each step. ch matches sel, valid=1, tick=0 throughout.
3. Scan mode from reset, en=1, 13 edges -> dout 11,11,11,22,22,22,33,33,33,44,44,44,11 (wraps to 11 on the 13th edge). tick=1 on edges 1,4,7,10,13.
4. Scan mode, en=0 for 5 cycles during the second 22 sample -> dout/ch/tick frozen at 22/1/0. After re-enable, exactly one more 22 sample, then 33 with tick=1.
5. NCH=3, manual, sel=3 -> dout=0, valid=0. Then sel=2 -> dout = channel-2 data, valid=1 one edge later.
6. Scan running at channel 2; switch to manual with sel=1 for 2 cycles, then back to scan -> dout 22,22, then scan restarts: 11 with tick=1, held for 3 cycles.
